pipe_ewb: RTL and testbench

- Back end of the 5-stage pipelined CPU. Holds the EXE, MEM and WB pipeline registers and drives the data-memory request/ready handshake.
- Produces every signal the decode stage consumes for forwarding, interlock and register writeback: ern/ewreg/em2reg, mrn/mwreg/mm2reg/malu/mmo, and wrn/wwreg/wdi.
- Receives the decode-stage control outputs and the EXE ALU result.
- Raises mstall to freeze the front end while a data access is outstanding.

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/pipe_ewb_if.sv | 29 ++
 rtl/pipe_memctl.sv | 73 +++++++
 rtl/pipe_ewb.sv | 140 ++++++++++++++
 tb/tb_pipe_ewb.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the EXE/MEM/WB pipeline back end.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int         DATA_W   = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic       wreg;
        logic       m2reg;
        logic       wmem;
        logic [4:0] rn;
    } ctl_t;

    function automatic logic is_access(input ctl_t c);
        return c.m2reg | c.wmem;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ewb_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ewb_if
// Description : Data-memory request/ready bus between the pipeline and memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ewb_if;
    import pipe_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              mem_err;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_err,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_err,
        output mem_rdata, mem_ready
    );

endinterface
`default_nettype wire

// File: rtl/pipe_memctl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_memctl
// Description : MEM-stage access sequencer: wait counting, timeout and stall.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_memctl
    import pipe_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  wire logic              clock,
    input  wire logic              resetn,
    input  wire logic              access_i,
    input  wire logic              mem_ready_i,
    input  wire logic [DATA_W-1:0] mem_rdata_i,
    output logic                   mem_req_o,
    output logic                   mstall_o,
    output logic                   mem_err_o,
    output logic [DATA_W-1:0]      mmo_o
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    mem_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    // A timed-out access gets one forced completion cycle with no request and zero data.
    assign mem_req_o = access_i && (state_q != ST_DONE);
    assign mstall_o  = mem_req_o && !mem_ready_i;
    assign mmo_o     = (mem_ready_i && (state_q != ST_DONE)) ? mem_rdata_i : '0;
    assign mem_err_o = err_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (mem_req_o && !mem_ready_i) begin
                        state_q <= ST_WAIT;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (mem_ready_i) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_W'(MAX_WAIT)) begin
                        state_q <= ST_DONE;
                        cnt_q   <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_ewb.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ewb
// Description : EXE/MEM/WB pipeline registers and data-memory handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ewb
    import pipe_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  wire logic              clock,
    input  wire logic              resetn,
    input  wire logic              wpcir,
    input  wire logic              dwreg,
    input  wire logic              dm2reg,
    input  wire logic              dwmem,
    input  wire logic [4:0]        drn,
    input  wire logic [DATA_W-1:0] db,
    input  wire logic [DATA_W-1:0] ealu,
    output logic                   ewreg,
    output logic                   em2reg,
    output logic                   ewmem,
    output logic [4:0]             ern,
    output logic                   mwreg,
    output logic                   mm2reg,
    output logic                   mwmem,
    output logic [4:0]             mrn,
    output logic [DATA_W-1:0]      malu,
    output logic [DATA_W-1:0]      mmo,
    output logic                   mstall,
    output logic                   wwreg,
    output logic [4:0]             wrn,
    output logic [DATA_W-1:0]      wdi,
    pipe_ewb_if.master             mem
);

    ctl_t              exe_q, exe_d;
    ctl_t              mem_q, mem_d;
    logic [DATA_W-1:0] eb_q, eb_d;
    logic [DATA_W-1:0] malu_q, malu_d;
    logic [DATA_W-1:0] mb_q, mb_d;
    logic              wwreg_q, wwreg_d;
    logic              wm2reg_q, wm2reg_d;
    logic [4:0]        wrn_q, wrn_d;
    logic [DATA_W-1:0] walu_q, walu_d;
    logic [DATA_W-1:0] wmo_q, wmo_d;
    logic              mem_req;
    logic              mem_err;

    pipe_memctl #(
        .MAX_WAIT (MAX_WAIT)
    ) u_memctl (
        .clock       (clock),
        .resetn      (resetn),
        .access_i    (is_access(mem_q)),
        .mem_ready_i (mem.mem_ready),
        .mem_rdata_i (mem.mem_rdata),
        .mem_req_o   (mem_req),
        .mstall_o    (mstall),
        .mem_err_o   (mem_err),
        .mmo_o       (mmo)
    );

    always_comb begin
        exe_d  = exe_q;
        eb_d   = eb_q;
        mem_d  = mem_q;
        malu_d = malu_q;
        mb_d   = mb_q;
        // A memory stall outranks a load-use bubble: EXE and MEM simply hold.
        if (!mstall) begin
            if (wpcir) begin
                exe_d.wreg  = dwreg && (drn != REG_ZERO);
                exe_d.m2reg = dm2reg;
                exe_d.wmem  = dwmem;
                exe_d.rn    = drn;
                eb_d        = db;
            end else begin
                exe_d = '0;
                eb_d  = '0;
            end
            mem_d  = exe_q;
            malu_d = ealu;
            mb_d   = eb_q;
        end
        wwreg_d  = mem_q.wreg && !mstall;
        wm2reg_d = mem_q.m2reg;
        wrn_d    = mem_q.rn;
        walu_d   = malu_q;
        wmo_d    = mmo;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            exe_q    <= '0;
            eb_q     <= '0;
            mem_q    <= '0;
            malu_q   <= '0;
            mb_q     <= '0;
            wwreg_q  <= 1'b0;
            wm2reg_q <= 1'b0;
            wrn_q    <= '0;
            walu_q   <= '0;
            wmo_q    <= '0;
        end else begin
            exe_q    <= exe_d;
            eb_q     <= eb_d;
            mem_q    <= mem_d;
            malu_q   <= malu_d;
            mb_q     <= mb_d;
            wwreg_q  <= wwreg_d;
            wm2reg_q <= wm2reg_d;
            wrn_q    <= wrn_d;
            walu_q   <= walu_d;
            wmo_q    <= wmo_d;
        end
    end

    assign ewreg  = exe_q.wreg;
    assign em2reg = exe_q.m2reg;
    assign ewmem  = exe_q.wmem;
    assign ern    = exe_q.rn;
    assign mwreg  = mem_q.wreg;
    assign mm2reg = mem_q.m2reg;
    assign mwmem  = mem_q.wmem;
    assign mrn    = mem_q.rn;
    assign malu   = malu_q;
    assign wwreg  = wwreg_q;
    assign wrn    = wrn_q;
    assign wdi    = wm2reg_q ? wmo_q : walu_q;

    assign mem.mem_req   = mem_req;
    assign mem.mem_we    = mem_q.wmem;
    assign mem.mem_addr  = malu_q;
    assign mem.mem_wdata = mb_q;
    assign mem.mem_err   = mem_err;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ewb.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ewb
// Description : Self-checking bench for pipe_ewb against a stage-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ewb;

    localparam int MAX_WAIT = 15;

    logic        clock = 1'b0;
    logic        resetn;
    logic        wpcir, dwreg, dm2reg, dwmem;
    logic [4:0]  drn;
    logic [31:0] db, ealu;
    logic        ewreg, em2reg, ewmem, mwreg, mm2reg, mwmem, mstall, wwreg;
    logic [4:0]  ern, mrn, wrn;
    logic [31:0] malu, mmo, wdi;

    pipe_ewb_if mem_if ();

    pipe_ewb #(.MAX_WAIT(MAX_WAIT)) dut (
        .clock (clock), .resetn (resetn), .wpcir (wpcir),
        .dwreg (dwreg), .dm2reg (dm2reg), .dwmem (dwmem), .drn (drn),
        .db (db), .ealu (ealu),
        .ewreg (ewreg), .em2reg (em2reg), .ewmem (ewmem), .ern (ern),
        .mwreg (mwreg), .mm2reg (mm2reg), .mwmem (mwmem), .mrn (mrn),
        .malu (malu), .mmo (mmo), .mstall (mstall),
        .wwreg (wwreg), .wrn (wrn), .wdi (wdi),
        .mem (mem_if)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one record per pipeline slot, plus how long MEM has waited.
    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [4:0]  rn;
        logic [31:0] b;
        logic [31:0] alu;
    } slot_t;

    slot_t       m_ex, m_mm, m_wb;
    logic [31:0] m_wmo;
    int          m_waited;
    bit          m_forced;

    function automatic void model_reset();
        m_ex = '0; m_mm = '0; m_wb = '0; m_wmo = '0; m_waited = 0; m_forced = 1'b0;
    endfunction

    function automatic logic x_req();
        return (m_mm.m2reg | m_mm.wmem) && !m_forced;
    endfunction

    function automatic logic x_stall();
        return x_req() && !mem_if.mem_ready;
    endfunction

    function automatic logic [31:0] x_mmo();
        return (mem_if.mem_ready && !m_forced) ? mem_if.mem_rdata : 32'h0;
    endfunction

    function automatic logic [31:0] x_wdi();
        return m_wb.m2reg ? m_wmo : m_wb.alu;
    endfunction

    function automatic void model_step();
        logic        st;
        logic [31:0] mo;
        st = x_stall();
        mo = x_mmo();
        m_wb      = m_mm;
        m_wb.wreg = m_mm.wreg && !st;
        m_wmo     = mo;
        if (m_forced) begin
            m_forced = 1'b0;
            m_waited = 0;
        end else if ((m_mm.m2reg | m_mm.wmem) && !mem_if.mem_ready) begin
            if (m_waited == MAX_WAIT) m_forced = 1'b1;
            else m_waited = m_waited + 1;
        end else begin
            m_waited = 0;
        end
        if (!st) begin
            m_mm     = m_ex;
            m_mm.alu = ealu;
            if (wpcir) m_ex = '{dwreg && (drn != 5'd0), dm2reg, dwmem, drn, db, 32'h0};
            else       m_ex = '0;
        end
    endfunction

    function automatic logic [121:0] exp_vec();
        return {m_ex.wreg, m_ex.m2reg, m_ex.wmem, m_ex.rn,
                m_mm.wreg, m_mm.m2reg, m_mm.wmem, m_mm.rn, m_mm.alu,
                x_mmo(), x_req(), m_mm.wmem, m_mm.alu, m_forced, x_stall(),
                m_wb.wreg, m_wb.rn};
    endfunction

    function automatic logic [121:0] dut_vec();
        return {ewreg, em2reg, ewmem, ern, mwreg, mm2reg, mwmem, mrn, malu,
                mmo, mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_err, mstall,
                wwreg, wrn};
    endfunction

    task automatic set_dec(input logic pc, input logic w, input logic l, input logic s,
                           input logic [4:0] rn, input logic [31:0] b);
        wpcir = pc; dwreg = w; dm2reg = l; dwmem = s; drn = rn; db = b;
    endtask

    task automatic nop();
        set_dec(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic clk_step();
        model_step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        nop();
        ealu = 32'h0;
        mem_if.mem_ready = 1'b0;
        mem_if.mem_rdata = 32'h0;
        model_reset();
        @(negedge clock);
        #1;
        n_vec++;
        if (dut_vec() !== 122'h0 || wdi !== 32'h0) begin
            n_err++;
            $display("FAIL reset got=%h wdi=%h exp=0", dut_vec(), wdi);
        end
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_alu();
        for (int c = 0; c < 4; c++) begin
            if (c == 0) set_dec(1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'h0);
            else nop();
            ealu = (c == 1) ? 32'h1234 : $urandom;
            #1;
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL alu_model c%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (c == 1) begin
                n_vec++;
                if ({ewreg, ern} !== {1'b1, 5'd5}) begin
                    n_err++;
                    $display("FAIL alu_exe got=%b/%0d exp=1/5", ewreg, ern);
                end
            end else if (c == 2) begin
                n_vec++;
                if ({mwreg, mrn, malu} !== {1'b1, 5'd5, 32'h1234}) begin
                    n_err++;
                    $display("FAIL alu_mem got=%b/%0d/%h exp=1/5/1234", mwreg, mrn, malu);
                end
            end else if (c == 3) begin
                n_vec++;
                if ({wwreg, wrn, wdi} !== {1'b1, 5'd5, 32'h1234}) begin
                    n_err++;
                    $display("FAIL alu_wb got=%b/%0d/%h exp=1/5/1234", wwreg, wrn, wdi);
                end
            end
            clk_step();
        end
    endtask

    task automatic test_load_ready();
        for (int c = 0; c < 4; c++) begin
            if (c == 0) set_dec(1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 32'h0);
            else nop();
            ealu = (c == 1) ? 32'h100 : $urandom;
            mem_if.mem_ready = (c == 2);
            mem_if.mem_rdata = (c == 2) ? 32'hDEADBEEF : $urandom;
            #1;
            n_vec++;
            if (dut_vec() !== exp_vec() || mstall !== 1'b0) begin
                n_err++;
                $display("FAIL ldrdy_model c%0d got=%h exp=%h stall=%b", c, dut_vec(), exp_vec(), mstall);
            end
            if (c == 2) begin
                n_vec++;
                if (mmo !== 32'hDEADBEEF) begin
                    n_err++;
                    $display("FAIL ldrdy_mmo got=%h exp=deadbeef", mmo);
                end
            end else if (c == 3) begin
                n_vec++;
                if ({wwreg, wrn, wdi} !== {1'b1, 5'd9, 32'hDEADBEEF}) begin
                    n_err++;
                    $display("FAIL ldrdy_wb got=%b/%0d/%h exp=1/9/deadbeef", wwreg, wrn, wdi);
                end
            end
            clk_step();
        end
        mem_if.mem_ready = 1'b0;
    endtask

    task automatic test_load_wait3();
        int stalls = 0;
        int writes = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 0)      set_dec(1'b1, 1'b1, 1'b1, 1'b0, 5'd10, 32'h0);
            else if (c == 1) set_dec(1'b1, 1'b1, 1'b0, 1'b0, 5'd11, 32'h0);
            else nop();
            ealu = (c == 1) ? 32'h200 : $urandom;
            mem_if.mem_ready = (c == 5);
            mem_if.mem_rdata = (c == 5) ? 32'hCAFE0001 : $urandom;
            #1;
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL wait3_model c%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (mstall === 1'b1) stalls++;
            if (wwreg === 1'b1 && wrn === 5'd10) begin
                writes++;
                n_vec++;
                if (wdi !== 32'hCAFE0001) begin
                    n_err++;
                    $display("FAIL wait3_wdi got=%h exp=cafe0001", wdi);
                end
            end
            clk_step();
        end
        n_vec++;
        if (stalls != 3 || writes != 1) begin
            n_err++;
            $display("FAIL wait3_counts stalls=%0d writes=%0d exp=3/1", stalls, writes);
        end
    endtask

    task automatic test_bubble();
        int writes = 0;
        for (int c = 0; c < 5; c++) begin
            if (c == 0) set_dec(1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 32'h77);
            else nop();
            ealu = $urandom;
            #1;
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL bubble_model c%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (c == 1) begin
                n_vec++;
                if ({ewreg, ern} !== {1'b0, 5'd0}) begin
                    n_err++;
                    $display("FAIL bubble_exe got=%b/%0d exp=0/0", ewreg, ern);
                end
            end
            if (wwreg === 1'b1 && wrn === 5'd7) writes++;
            clk_step();
        end
        n_vec++;
        if (writes != 0) begin
            n_err++;
            $display("FAIL bubble_r7 writes=%0d exp=0", writes);
        end
    endtask

    task automatic test_r0();
        for (int c = 0; c < 4; c++) begin
            if (c == 0) set_dec(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
            else nop();
            ealu = $urandom;
            #1;
            n_vec++;
            if (dut_vec() !== exp_vec() || {ewreg, mwreg, wwreg} !== 3'b000) begin
                n_err++;
                $display("FAIL r0 c%0d got=%h exp=%h we=%b", c, dut_vec(), exp_vec(), {ewreg, mwreg, wwreg});
            end
            clk_step();
        end
    endtask

    task automatic test_timeout();
        int  stalls = 0;
        bit  seen   = 1'b0;
        mem_if.mem_ready = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            if (c == 0) set_dec(1'b1, 1'b1, 1'b1, 1'b0, 5'd12, 32'h0);
            else nop();
            ealu = (c == 1) ? 32'h300 : $urandom;
            mem_if.mem_rdata = $urandom;
            #1;
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL tmo_model c%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (mstall === 1'b1) stalls++;
            if (mem_if.mem_err === 1'b1) begin
                seen = 1'b1;
                n_vec++;
                if (mstall !== 1'b0 || mmo !== 32'h0 || mem_if.mem_req !== 1'b0) begin
                    n_err++;
                    $display("FAIL tmo_done stall=%b mmo=%h req=%b exp=0/0/0", mstall, mmo, mem_if.mem_req);
                end
            end
            clk_step();
        end
        n_vec++;
        if (!seen || stalls != MAX_WAIT + 1) begin
            n_err++;
            $display("FAIL tmo_err seen=%0d stalls=%0d exp=1/%0d", seen, stalls, MAX_WAIT + 1);
        end
        #1;
        n_vec++;
        if ({wwreg, wrn, wdi} !== {1'b1, 5'd12, 32'h0}) begin
            n_err++;
            $display("FAIL tmo_wb got=%b/%0d/%h exp=1/12/0", wwreg, wrn, wdi);
        end
        // Second load, abandoned by reset while waiting.
        for (int c = 0; c < 6; c++) begin
            if (c == 0) set_dec(1'b1, 1'b1, 1'b1, 1'b0, 5'd13, 32'h0);
            else nop();
            ealu = $urandom;
            #1;
            clk_step();
        end
        #2;
        n_vec++;
        if (mem_if.mem_req !== 1'b1) begin
            n_err++;
            $display("FAIL rst_pre req=%b exp=1", mem_if.mem_req);
        end
        resetn = 1'b0;
        #1;
        n_vec++;
        if ({mem_if.mem_req, mstall, mem_if.mem_err} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_mid req/stall/err=%b exp=000", {mem_if.mem_req, mstall, mem_if.mem_err});
        end
        model_reset();
        @(negedge clock);
        resetn = 1'b1;
        nop();
        #1;
        n_vec++;
        if (dut_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL rst_after got=%h exp=%h", dut_vec(), exp_vec());
        end
        clk_step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            set_dec($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
                    5'($urandom_range(0, 31)), $urandom);
            ealu             = $urandom;
            mem_if.mem_ready = $urandom_range(0, 2) == 0;
            mem_if.mem_rdata = $urandom;
            #1;
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL rand_model c%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (m_wb.wreg) begin
                n_vec++;
                if (wdi !== x_wdi()) begin
                    n_err++;
                    $display("FAIL rand_wdi c%0d got=%h exp=%h", c, wdi, x_wdi());
                end
            end
            if (x_req() && m_mm.wmem) begin
                n_vec++;
                if (mem_if.mem_wdata !== m_mm.b) begin
                    n_err++;
                    $display("FAIL rand_wdata c%0d got=%h exp=%h", c, mem_if.mem_wdata, m_mm.b);
                end
            end
            clk_step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_load_ready();
        test_load_wait3();
        test_bubble();
        test_r0();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
